pc_gen: RTL and testbench

Parametrised program-counter generator for the pipelined MIPS core, successor to the single-cycle PC register. It holds the fetch address, selects the next address among sequential, branch, jump, exception-entry and exception-return sources, supports pipeline stall, and owns the EPC and EXL exception state. It sits at the head of the IF stage and feeds the instruction memory address and the IF/ID pipeline register.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_gen_if.sv | 35 +++
 rtl/pc_next_sel.sv | 54 +++++
 rtl/pc_gen.sv | 103 ++++++++++
 tb/tb_pc_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared constants and enums for the IF-stage program-counter generator.
package pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam int unsigned DEF_STEP      = 4;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_EXC,
    SRC_ERET
  } pc_src_e;

  typedef enum logic {
    MODE_NORMAL,
    MODE_HANDLER
  } pc_mode_e;

  // Bits of a redirect target that must be zero; STEP=1 yields an empty mask.
  function automatic int unsigned align_mask(input int unsigned step);
    return step - 1;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/redirect inputs and fetch-address outputs of pc_gen, plus the mode debug view.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  // Requests carry no handshake: every request line is a level sampled on each
  // rising clk edge and acted on in that cycle only; the PC never back-pressures.
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jmp;
  logic [WIDTH-1:0] jmp_target;
  logic             exc_req;
  logic [WIDTH-1:0] epc_in;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_step;
  logic [WIDTH-1:0] epc;
  logic             exl;
  logic             fetch_adel;
  pc_mode_e         mode;

  modport slave (
    input  stall, br_taken, br_target, jmp, jmp_target, exc_req, epc_in, eret,
    output pc, pc_step, epc, exl, fetch_adel, mode
  );

  modport master (
    output stall, br_taken, br_target, jmp, jmp_target, exc_req, epc_in, eret,
    input  pc, pc_step, epc, exl, fetch_adel, mode
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority select: picks the source, its target and flags misalignment.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned      STEP    = DEF_STEP
) (
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             exl,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  output logic             hold,
  output pc_src_e          src,
  output logic [WIDTH-1:0] target,
  output logic             misalign,
  output logic [WIDTH-1:0] pc_step
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(align_mask(STEP));

  assign pc_step = pc + WIDTH'(STEP);

  always_comb begin
    hold     = 1'b0;
    src      = SRC_SEQ;
    target   = pc_step;
    misalign = 1'b0;
    if (exc_req) begin
      src    = SRC_EXC;
      target = EXC_VEC;
    end else if (eret && exl) begin
      src    = SRC_ERET;
      target = epc;
    end else if (stall) begin
      hold = 1'b1;
    end else if (jmp) begin
      src      = SRC_JMP;
      target   = jmp_target;
      misalign = |(jmp_target & MASK);
    end else if (br_taken) begin
      src      = SRC_BR;
      target   = br_target;
      misalign = |(br_target & MASK);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fetch PC, EPC and the NORMAL/HANDLER exception mode.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned      STEP      = DEF_STEP
) (
  input  logic     clk,
  input  logic     reset_n,
  pc_gen_if.slave  bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  pc_mode_e         mode_q, mode_d;
  logic             adel_q, adel_d;

  logic             exl;
  logic             hold;
  pc_src_e          src;
  logic [WIDTH-1:0] target;
  logic             misalign;
  logic [WIDTH-1:0] pc_step;

  assign exl = (mode_q == MODE_HANDLER);

  pc_next_sel #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC),
    .STEP    (STEP)
  ) u_sel (
    .stall      (bus.stall),
    .br_taken   (bus.br_taken),
    .br_target  (bus.br_target),
    .jmp        (bus.jmp),
    .jmp_target (bus.jmp_target),
    .exc_req    (bus.exc_req),
    .eret       (bus.eret),
    .exl        (exl),
    .pc         (pc_q),
    .epc        (epc_q),
    .hold       (hold),
    .src        (src),
    .target     (target),
    .misalign   (misalign),
    .pc_step    (pc_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_VEC;
      epc_q  <= '0;
      mode_q <= MODE_NORMAL;
      adel_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      mode_q <= mode_d;
      adel_q <= adel_d;
    end
  end

  // EPC is captured only on the NORMAL->HANDLER transition so nested faults keep the first one.
  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    mode_d = mode_q;
    adel_d = 1'b0;
    if (!hold) begin
      case (src)
        SRC_EXC: begin
          pc_d   = EXC_VEC;
          mode_d = MODE_HANDLER;
          if (!exl) epc_d = bus.epc_in;
        end
        SRC_ERET: begin
          pc_d   = target;
          mode_d = MODE_NORMAL;
        end
        default: begin
          if (misalign) begin
            pc_d   = EXC_VEC;
            adel_d = 1'b1;
            mode_d = MODE_HANDLER;
            if (!exl) epc_d = target;
          end else begin
            pc_d = target;
          end
        end
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_step    = pc_step;
  assign bus.epc        = epc_q;
  assign bus.exl        = exl;
  assign bus.fetch_adel = adel_q;
  assign bus.mode       = mode_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a behavioural next-PC model feeds an expected queue checked every cycle.
module tb_pc_gen;
  import pc_pkg::*;

  localparam int          W     = 32;
  localparam int unsigned STEP  = 4;
  localparam logic [31:0] RST_V = 32'h0000_3000;
  localparam logic [31:0] EXC_V = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  pc_gen_if #(.WIDTH(W)) bus ();

  pc_gen #(
    .WIDTH     (W),
    .RESET_VEC (RST_V),
    .EXC_VEC   (EXC_V),
    .STEP      (STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state and scoreboard ----------------
  logic [31:0]      m_pc, m_epc;
  logic             m_exl, m_adel;
  logic [2*W+1:0]   exp_q[$];
  logic [2*W+1:0]   cmp_e;

  function automatic logic [31:0] seq_of(input logic [31:0] a);
    return 32'((64'(a) + 64'(STEP)) % 64'h1_0000_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_V;
    m_epc  = '0;
    m_exl  = 1'b0;
    m_adel = 1'b0;
  endtask

  // Next state straight from the priority rules: exception, valid return, stall, redirect/sequential.
  task automatic model_step(input logic st, input logic br, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt,
                            input logic ex, input logic [31:0] ei, input logic er);
    logic [31:0] tgt;
    logic        redir;
    m_adel = 1'b0;
    if (ex) begin
      if (!m_exl) m_epc = ei;
      m_exl = 1'b1;
      m_pc  = EXC_V;
    end else if (er && m_exl) begin
      m_pc  = m_epc;
      m_exl = 1'b0;
    end else if (!st) begin
      redir = j || br;
      tgt   = j ? jt : (br ? bt : seq_of(m_pc));
      if (redir && (tgt % STEP) != 0) begin
        if (!m_exl) m_epc = tgt;
        m_exl  = 1'b1;
        m_adel = 1'b1;
        m_pc   = EXC_V;
      end else begin
        m_pc = tgt;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic st, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic ex, input logic [31:0] ei, input logic er);
    bus.stall      = st;
    bus.br_taken   = br;
    bus.br_target  = bt;
    bus.jmp        = j;
    bus.jmp_target = jt;
    bus.exc_req    = ex;
    bus.epc_in     = ei;
    bus.eret       = er;
    @(posedge clk);
    model_step(st, br, bt, j, jt, ex, ei, er);
    exp_q.push_back({m_pc, m_epc, m_exl, m_adel});
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Hand-computed values pin both the DUT and the model.
  task automatic pin_pc(input string name, input logic [31:0] exp);
    check({name, "_pc"}, bus.pc, exp);
    check({name, "_model_pc"}, m_pc, exp);
  endtask

  task automatic pin_state(input string name, input logic [31:0] epc, input logic exl, input logic adel);
    check({name, "_epc"}, bus.epc, epc);
    check({name, "_exl"}, {31'b0, bus.exl}, {31'b0, exl});
    check({name, "_adel"}, {31'b0, bus.fetch_adel}, {31'b0, adel});
    check({name, "_model_epc"}, m_epc, epc);
    check({name, "_model_exl"}, {31'b0, m_exl}, {31'b0, exl});
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_pc"}, bus.pc, RST_V);
    check({name, "_epc"}, bus.epc, 32'h0);
    check({name, "_exl"}, {31'b0, bus.exl}, 32'h0);
    check({name, "_adel"}, {31'b0, bus.fetch_adel}, 32'h0);
    check({name, "_pc_step"}, bus.pc_step, RST_V + 32'd4);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      check("cyc_pc", bus.pc, cmp_e[2*W+1:W+2]);
      check("cyc_epc", bus.epc, cmp_e[W+1:2]);
      check("cyc_exl", {31'b0, bus.exl}, {31'b0, cmp_e[1]});
      check("cyc_adel", {31'b0, bus.fetch_adel}, {31'b0, cmp_e[0]});
      check("cyc_pc_step", bus.pc_step, seq_of(cmp_e[2*W+1:W+2]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0; bus.jmp = 1'b0;
    bus.jmp_target = '0; bus.exc_req = 1'b0; bus.epc_in = '0; bus.eret = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;

    idle(); pin_pc("seq1", 32'h3004);
    idle(); pin_pc("seq2", 32'h3008);
    idle(); pin_pc("seq3", 32'h300C);
    pin_state("seq3", 32'h0, 1'b0, 1'b0);

    cycle(1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); pin_pc("stall1", 32'h300C);
    cycle(1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); pin_pc("stall2", 32'h300C);
    cycle(1'b0, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); pin_pc("branch", 32'h3100);

    cycle(1'b0, 1'b1, 32'h3100, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b0); pin_pc("jmp_over_br", 32'h3200);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h3202, 1'b0, 32'h0, 1'b0); pin_pc("jmp_misalign", 32'h4180);
    pin_state("jmp_misalign", 32'h3202, 1'b1, 1'b1);
    idle(); pin_pc("handler_seq", 32'h4184);
    pin_state("handler_seq", 32'h3202, 1'b1, 1'b0);

    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); pin_pc("eret_adel", 32'h3202);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h3020, 1'b0, 32'h0, 1'b0); pin_pc("jmp_back", 32'h3020);

    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h3010, 1'b0); pin_pc("exc_stall", 32'h4180);
    pin_state("exc_stall", 32'h3010, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4184, 1'b0); pin_pc("exc_nested", 32'h4180);
    pin_state("exc_nested", 32'h3010, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); pin_pc("eret", 32'h3010);
    pin_state("eret", 32'h3010, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); pin_pc("eret_no_exl", 32'h3014);

    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h3014, 1'b1); pin_pc("exc_and_eret", 32'h4180);
    pin_state("exc_and_eret", 32'h3014, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h3101, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); pin_pc("br_misalign_nested", 32'h4180);
    pin_state("br_misalign_nested", 32'h3014, 1'b1, 1'b1);

    // Asynchronous reset between edges while a redirect is being requested.
    bus.jmp = 1'b1;
    bus.jmp_target = 32'h3300;
    #1 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    #1 reset_n = 1'b1;

    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0); pin_pc("jmp_top", 32'hFFFF_FFFC);
    idle(); pin_pc("wrap", 32'h0000_0000);
    pin_state("wrap", 32'h0, 1'b0, 1'b0);
    idle(); pin_pc("after_wrap", 32'h0000_0004);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); pin_pc("plain_stall", 32'h0000_0004);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is short, so any overrun is a failure.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion before 20000");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
